// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage with PC and direct-mapped one-word-per-line cache
// Hits are served from the cache, misses go out as a held fetch request to the memory controller.
module inst_fetch #(
   parameter int          INDEX_W  = 6,
   parameter int          TAG_W    = 10,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        jump_i,
   input  logic [31:0] jump_addr_i,
   output logic        inst_req_o,
   output logic [31:0] inst_addr_o,
   input  logic [31:0] inst_i,
   input  logic [31:0] inst_pc_i,
   input  logic        inst_done_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o
);

   localparam int LINES = 1 << INDEX_W;

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_MISS = 1'b1;

   logic [0:0]       state;
   logic [31:0]      pc;
   logic [31:0]      pc_next;

   logic [LINES-1:0] line_valid;
   logic [TAG_W-1:0] line_tag  [LINES];
   logic [31:0]      line_data [LINES];

   logic [INDEX_W-1:0] pc_idx;
   logic [TAG_W-1:0]   pc_tag;
   logic [INDEX_W-1:0] fill_idx;
   logic [TAG_W-1:0]   fill_tag;
   logic               hit;
   logic               done_match;

   assign pc_idx   = pc[INDEX_W+1:2];
   assign pc_tag   = pc[INDEX_W+TAG_W+1:INDEX_W+2];
   assign fill_idx = inst_pc_i[INDEX_W+1:2];
   assign fill_tag = inst_pc_i[INDEX_W+TAG_W+1:INDEX_W+2];

   assign hit        = line_valid[pc_idx] && (line_tag[pc_idx] == pc_tag);
   assign done_match = inst_done_i && (inst_pc_i == pc);
   assign pc_next    = pc + 32'd4;

   // Tag/data storage carries no reset: a line is only trusted once its valid bit is set.
   always_ff @(posedge clk) begin
      if (inst_done_i) begin
         line_tag[fill_idx]  <= fill_tag;
         line_data[fill_idx] <= inst_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         line_valid   <= '0;
         pc           <= RESET_PC;
         state        <= ST_RUN;
         inst_req_o   <= 1'b0;
         inst_addr_o  <= 32'h0;
         inst_valid_o <= 1'b0;
         inst_o       <= 32'h0;
         pc_o         <= 32'h0;
      end else begin
         // Completions always fill, even stale ones or those landing after a redirect.
         if (inst_done_i) begin
            line_valid[fill_idx] <= 1'b1;
         end

         inst_valid_o <= 1'b0;

         if (jump_i) begin
            pc         <= jump_addr_i;
            state      <= ST_RUN;
            inst_req_o <= 1'b0;
         end else begin
            case (state)
               ST_RUN: begin
                  if (!stall_i) begin
                     if (hit) begin
                        inst_valid_o <= 1'b1;
                        inst_o       <= line_data[pc_idx];
                        pc_o         <= pc;
                        pc           <= pc_next;
                     end else begin
                        inst_req_o  <= 1'b1;
                        inst_addr_o <= pc;
                        state       <= ST_MISS;
                     end
                  end
               end
               ST_MISS: begin
                  if (done_match) begin
                     inst_req_o <= 1'b0;
                     state      <= ST_RUN;
                     // Under stall the fill alone suffices: the line hits once stall clears.
                     if (!stall_i) begin
                        inst_valid_o <= 1'b1;
                        inst_o       <= inst_i;
                        pc_o         <= pc;
                        pc           <= pc_next;
                     end
                  end
               end
               default: begin
                  state      <= ST_RUN;
                  inst_req_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch
// Memory controller and expected instruction stream are modelled inside the bench.
module tb_inst_fetch;

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic        jump_i;
   logic [31:0] jump_addr_i;
   logic        inst_req_o;
   logic [31:0] inst_addr_o;
   logic [31:0] inst_i;
   logic [31:0] inst_pc_i;
   logic        inst_done_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] pc_o;

   inst_fetch dut (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall_i),
      .jump_i       (jump_i),
      .jump_addr_i  (jump_addr_i),
      .inst_req_o   (inst_req_o),
      .inst_addr_o  (inst_addr_o),
      .inst_i       (inst_i),
      .inst_pc_i    (inst_pc_i),
      .inst_done_i  (inst_done_i),
      .inst_valid_o (inst_valid_o),
      .inst_o       (inst_o),
      .pc_o         (pc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          n_out    = 0;
   logic [31:0] exp_pc   = 32'h0;
   logic        mem_busy = 1'b0;
   int          mem_cnt  = 0;
   logic [31:0] mem_addr = 32'h0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h0) ? 32'h00000013 : ((a * 32'h9E3779B1) ^ 32'h00C0FFEE);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: output monitor against the expected stream, then the memory controller model.
   task automatic tick();
      logic        p_stall, p_jump, p_rst;
      logic [31:0] p_jaddr;
      p_stall = stall_i;
      p_jump  = jump_i;
      p_rst   = rst;
      p_jaddr = jump_addr_i;
      @(posedge clk);
      #1;
      if (inst_valid_o === 1'b1) begin
         n_out++;
         chk("out_pc", pc_o, exp_pc);
         chk("out_inst", inst_o, mem_word(pc_o));
         chk("out_legal", {31'b0, p_stall | p_jump | p_rst}, 32'h0);
      end
      if (p_rst)                    exp_pc = 32'h0;
      else if (p_jump)              exp_pc = p_jaddr;
      else if (inst_valid_o === 1'b1) exp_pc = exp_pc + 32'd4;

      inst_done_i = 1'b0;
      if (mem_busy) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            inst_done_i = 1'b1;
            inst_i      = mem_word(mem_addr);
            inst_pc_i   = mem_addr;
            mem_busy    = 1'b0;
         end
      end else if (inst_req_o === 1'b1) begin
         mem_busy = 1'b1;
         mem_addr = inst_addr_o;
         mem_cnt  = int'($urandom_range(6, 9));
      end
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         tick();
         if (inst_valid_o === 1'b1) break;
      end
      chk(tag, {31'b0, inst_valid_o}, 32'h1);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && mem_busy; i++) tick();
      chk("drain", {31'b0, mem_busy}, 32'h0);
   endtask

   task automatic do_jump(input logic [31:0] a);
      jump_i      = 1'b1;
      jump_addr_i = a;
      tick();
      jump_i      = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      stall_i     = 1'b0;
      jump_i      = 1'b0;
      jump_addr_i = 32'h0;
      inst_i      = 32'h0;
      inst_pc_i   = 32'h0;
      inst_done_i = 1'b0;

      tick();
      tick();
      chk("rst_req", {31'b0, inst_req_o}, 32'h0);
      chk("rst_addr", inst_addr_o, 32'h0);
      chk("rst_valid", {31'b0, inst_valid_o}, 32'h0);
      chk("rst_inst", inst_o, 32'h0);
      chk("rst_pc", pc_o, 32'h0);

      // Cold start
      rst = 1'b0;
      tick();
      chk("cold_req", {31'b0, inst_req_o}, 32'h1);
      chk("cold_addr", inst_addr_o, 32'h0);
      wait_valid("cold_valid", 40);
      chk("cold_pc", pc_o, 32'h0);
      chk("cold_inst", inst_o, 32'h00000013);
      tick();
      chk("next_req", {31'b0, inst_req_o}, 32'h1);
      chk("next_addr", inst_addr_o, 32'h4);
      begin
         int i;
         for (i = 0; i < 200; i++) begin
            tick();
            if (inst_valid_o === 1'b1 && pc_o === 32'hC) break;
         end
         chk("warm_done", {31'b0, inst_valid_o}, 32'h1);
      end

      // Warm refetch: four back-to-back hits
      do_jump(32'h0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("warm_valid", {31'b0, inst_valid_o}, 32'h1);
         chk("warm_pc", pc_o, 32'(k * 4));
         chk("warm_noreq", {31'b0, inst_req_o}, 32'h0);
      end

      // Stall during hits
      do_jump(32'h0);
      tick();
      chk("pre_stall_pc", pc_o, 32'h0);
      stall_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_valid", {31'b0, inst_valid_o}, 32'h0);
      end
      stall_i = 1'b0;
      tick();
      chk("resume_valid", {31'b0, inst_valid_o}, 32'h1);
      chk("resume_pc", pc_o, 32'h4);

      // Jump while in MISS; late completion only fills
      drain();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      do_jump(32'h8);
      tick();
      chk("miss8_req", {31'b0, inst_req_o}, 32'h1);
      chk("miss8_addr", inst_addr_o, 32'h8);
      do_jump(32'h100);
      chk("jump_dropreq", {31'b0, inst_req_o}, 32'h0);
      tick();
      chk("miss100_req", {31'b0, inst_req_o}, 32'h1);
      chk("miss100_addr", inst_addr_o, 32'h100);
      wait_valid("v100", 40);
      chk("v100_pc", pc_o, 32'h100);
      do_jump(32'h8);
      tick();
      chk("line2_hit", {31'b0, inst_valid_o}, 32'h1);
      chk("line2_pc", pc_o, 32'h8);
      chk("line2_noreq", {31'b0, inst_req_o}, 32'h0);

      // Alias on index 0
      drain();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_valid("al0", 40);
      chk("al0_pc", pc_o, 32'h0);
      do_jump(32'h100);
      tick();
      chk("al100_req", {31'b0, inst_req_o}, 32'h1);
      chk("al100_addr", inst_addr_o, 32'h100);
      wait_valid("al100", 40);
      chk("al100_pc", pc_o, 32'h100);
      do_jump(32'h0);
      tick();
      chk("al0_miss_valid", {31'b0, inst_valid_o}, 32'h0);
      chk("al0_miss_req", {31'b0, inst_req_o}, 32'h1);
      chk("al0_miss_addr", inst_addr_o, 32'h0);

      // Reset during MISS
      rst = 1'b1;
      tick();
      chk("rmiss_req", {31'b0, inst_req_o}, 32'h0);
      chk("rmiss_valid", {31'b0, inst_valid_o}, 32'h0);
      chk("rmiss_addr", inst_addr_o, 32'h0);
      rst = 1'b0;
      tick();
      chk("rmiss_pc_req", {31'b0, inst_req_o}, 32'h1);
      chk("rmiss_pc_addr", inst_addr_o, 32'h0);
      do_jump(32'h100);
      tick();
      chk("rmiss_inval_req", {31'b0, inst_req_o}, 32'h1);
      chk("rmiss_inval_addr", inst_addr_o, 32'h100);

      // Random stall/jump/reset traffic
      drain();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_out = 0;
      for (int k = 0; k < 4000; k++) begin
         stall_i     = ($urandom_range(0, 3) == 0);
         jump_i      = ($urandom_range(0, 29) == 0);
         jump_addr_i = 32'($urandom_range(0, 1023)) << 2;
         rst         = ($urandom_range(0, 499) == 0);
         tick();
      end
      rst     = 1'b0;
      stall_i = 1'b0;
      jump_i  = 1'b0;
      chk("progress", {31'b0, n_out > 100}, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
